// File: rtl/i2s_rx_deserializer.sv
// I2S receiver: turns a 16-bit stereo serial stream into left/right sample pairs
// and offers each pair to the audio datapath through a valid/ready handshake.
module i2s_rx_deserializer #(
    parameter int SAMPLE_WIDTH = 16
) (
    input  logic                    serial_clk,
    input  logic                    reset,
    input  logic                    ws_in,
    input  logic                    sd_in,
    input  logic                    clear_flags,
    input  logic                    sample_ready,
    output logic [SAMPLE_WIDTH-1:0] left_sample,
    output logic [SAMPLE_WIDTH-1:0] right_sample,
    output logic                    sample_valid,
    output logic                    locked,
    output logic                    overflow,
    output logic                    frame_error
);

    localparam int CW = $clog2(SAMPLE_WIDTH + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(SAMPLE_WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(SAMPLE_WIDTH - 1);

    localparam logic [1:0] ST_UNLOCKED = 2'd0;
    localparam logic [1:0] ST_LEFT     = 2'd1;
    localparam logic [1:0] ST_RIGHT    = 2'd2;

    logic                    ws_q;
    logic                    ws_prev;
    logic                    sd_q;
    logic [1:0]              state;
    logic [CW-1:0]           bit_cnt;
    logic                    left_pending;
    logic [SAMPLE_WIDTH-1:0] shift_reg;
    logic [SAMPLE_WIDTH-1:0] left_hold;

    logic                    ws_edge;
    logic                    in_slot;
    logic                    take_bit;
    logic                    slot_done;
    logic                    slot_short;
    logic                    pair_done;
    logic                    transfer;
    logic                    load_pair;
    logic [SAMPLE_WIDTH-1:0] shift_next;

    // NOTE: every signal below is assigned on every pass, so no latch can be inferred.
    always_comb begin
        ws_edge    = (ws_q != ws_prev);
        in_slot    = (state != ST_UNLOCKED);
        take_bit   = in_slot && (bit_cnt < FULL_CNT);
        shift_next = {shift_reg[SAMPLE_WIDTH-2:0], sd_q};
        slot_done  = take_bit && (bit_cnt == LAST_CNT);
        // The bit on the edge cycle still belongs to the old slot, so a slot is
        // short only if that final bit does not bring it to SAMPLE_WIDTH.
        slot_short = in_slot && ws_edge && !slot_done && (bit_cnt != FULL_CNT);
        pair_done  = slot_done && (state == ST_RIGHT) && left_pending;
        transfer   = sample_valid && sample_ready;
        load_pair  = pair_done && (!sample_valid || sample_ready);
    end

    // NOTE: registers use non-blocking assignments so every update sees pre-edge values.
    always_ff @(posedge serial_clk or negedge reset) begin
        if (!reset) begin
            ws_q         <= 1'b0;
            ws_prev      <= 1'b0;
            sd_q         <= 1'b0;
            state        <= ST_UNLOCKED;
            bit_cnt      <= '0;
            left_pending <= 1'b0;
            left_sample  <= '0;
            right_sample <= '0;
            sample_valid <= 1'b0;
            locked       <= 1'b0;
            overflow     <= 1'b0;
            frame_error  <= 1'b0;
        end else begin
            ws_q    <= ws_in;
            sd_q    <= sd_in;
            ws_prev <= ws_q;

            if (take_bit) begin
                bit_cnt <= bit_cnt + CW'(1);
            end

            // Unlocked, only a falling ws edge starts a slot; rising edges are ignored.
            if (ws_edge && (in_slot || !ws_q)) begin
                state   <= ws_q ? ST_RIGHT : ST_LEFT;
                bit_cnt <= '0;
                locked  <= 1'b1;
            end

            if (slot_short || (slot_done && state == ST_RIGHT)) begin
                left_pending <= 1'b0;
            end else if (slot_done && state == ST_LEFT) begin
                left_pending <= 1'b1;
            end

            if (load_pair) begin
                left_sample  <= left_hold;
                right_sample <= shift_next;
                sample_valid <= 1'b1;
            end else if (transfer) begin
                sample_valid <= 1'b0;
            end

            if (pair_done && !load_pair) begin
                overflow <= 1'b1;
            end else if (clear_flags) begin
                overflow <= 1'b0;
            end

            if (slot_short) begin
                frame_error <= 1'b1;
            end else if (clear_flags) begin
                frame_error <= 1'b0;
            end
        end
    end

    // NOTE: shift and holding registers carry no reset; they are always rewritten before use.
    always_ff @(posedge serial_clk) begin
        if (take_bit) begin
            shift_reg <= shift_next;
        end
        if (slot_done && state == ST_LEFT) begin
            left_hold <= shift_next;
        end
    end

endmodule
